// File: rtl/ecc_bank_resp.sv
// Two-port responder over two single-ported SEC-DED protected banks, with round-robin
// same-bank arbitration and a one-deep hold per port. ECC_ERR_INJ_EN adds write-side error injection masks.
module ecc_bank_resp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    localparam int P  = $clog2(DATA_WIDTH + 1 + $clog2(DATA_WIDTH + 1 + $clog2(DATA_WIDTH + 1))),
    localparam int CW = DATA_WIDTH + P + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ena,
    input  logic                  i_enb,
    input  logic                  i_wea,
    input  logic                  i_web,
    input  logic [DATA_WIDTH-1:0] i_dina,
    input  logic [DATA_WIDTH-1:0] i_dinb,
    input  logic [ADDR_WIDTH-1:0] i_addra,
    input  logic [ADDR_WIDTH-1:0] i_addrb,
`ifdef ECC_ERR_INJ_EN
    input  logic [CW-1:0]         i_inj_maska,
    input  logic [CW-1:0]         i_inj_maskb,
`endif
    output logic                  o_rdya,
    output logic                  o_rdyb,
    output logic [DATA_WIDTH-1:0] o_douta,
    output logic [DATA_WIDTH-1:0] o_doutb,
    output logic                  o_vala,
    output logic                  o_valb,
    output logic                  o_sbea,
    output logic                  o_sbeb,
    output logic                  o_dbea,
    output logic                  o_dbeb
);

    localparam int RW   = ADDR_WIDTH - 1;
    localparam int ROWS = 2 ** RW;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
        logic [CW-1:0]         mask;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sbe;
        logic                  dbe;
    } dec_t;

    // Parity at power-of-2 positions, data LSB-first elsewhere, overall parity in bit 0.
    function automatic logic [CW-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
        logic [CW-1:0] cw;
        int            k;
        cw = '0;
        k  = 0;
        for (int j = 1; j < CW; j++) begin
            if ((j & (j - 1)) != 0) begin
                cw[j] = d[k];
                k++;
            end
        end
        for (int i = 0; i < P; i++) begin
            for (int j = 1; j < CW; j++) begin
                if ((((j >> i) & 1) == 1) && (j != (1 << i)))
                    cw[1 << i] = cw[1 << i] ^ cw[j];
            end
        end
        cw[0] = ^cw[CW-1:1];
        return cw;
    endfunction

    function automatic dec_t ecc_decode(input logic [CW-1:0] cw_in);
        logic [CW-1:0] cw;
        logic [P-1:0]  syn;
        logic          par;
        int            k;
        int            idx;
        dec_t          r;
        cw  = cw_in;
        syn = '0;
        for (int j = 1; j < CW; j++) begin
            if (cw[j]) syn = syn ^ j[P-1:0];
        end
        par   = ^cw;
        r.sbe = par;
        r.dbe = !par && (syn != '0);
        idx   = int'(syn);
        if (par && (idx < CW)) cw[idx] = ~cw[idx];
        r.data = '0;
        k      = 0;
        for (int j = 1; j < CW; j++) begin
            if ((j & (j - 1)) != 0) begin
                r.data[k] = cw[j];
                k++;
            end
        end
        return r;
    endfunction

    req_t fresh_a, fresh_b, cur_a, cur_b, hold_a_q, hold_b_q;
    logic hold_a_v_q, hold_b_v_q, ptr_q;
    logic req_a, req_b, same_bank, lose_a, lose_b, exec_a, exec_b, fresh_pair;
    logic rd_pend_a_q, rd_pend_b_q, rd_bank_a_q, rd_bank_b_q;
    logic [CW-1:0] bank_rd [2];
    dec_t dec_a, dec_b;

    // Ready is the inverse of the hold flag, so it is registered by construction.
    assign o_rdya = ~hold_a_v_q;
    assign o_rdyb = ~hold_b_v_q;

    always_comb begin
        fresh_a.we   = i_wea;
        fresh_a.addr = i_addra;
        fresh_a.din  = i_dina;
        fresh_b.we   = i_web;
        fresh_b.addr = i_addrb;
        fresh_b.din  = i_dinb;
`ifdef ECC_ERR_INJ_EN
        fresh_a.mask = i_inj_maska;
        fresh_b.mask = i_inj_maskb;
`else
        fresh_a.mask = '0;
        fresh_b.mask = '0;
`endif
    end

    // A held request always wins; the pointer only arbitrates between two fresh requests.
    always_comb begin
        req_a      = hold_a_v_q | (i_ena & ~hold_a_v_q);
        req_b      = hold_b_v_q | (i_enb & ~hold_b_v_q);
        cur_a      = hold_a_v_q ? hold_a_q : fresh_a;
        cur_b      = hold_b_v_q ? hold_b_q : fresh_b;
        same_bank  = req_a & req_b & (cur_a.addr[0] == cur_b.addr[0]);
        fresh_pair = same_bank & ~hold_a_v_q & ~hold_b_v_q;
        lose_a     = 1'b0;
        lose_b     = 1'b0;
        if (same_bank) begin
            if (hold_a_v_q)      lose_b = 1'b1;
            else if (hold_b_v_q) lose_a = 1'b1;
            else if (ptr_q)      lose_a = 1'b1;
            else                 lose_b = 1'b1;
        end
        exec_a = req_a & ~lose_a;
        exec_b = req_b & ~lose_b;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [CW-1:0] mem [ROWS];
        logic [CW-1:0] rdata_q;
        logic          sel_a, sel_b, bank_we;
        logic [RW-1:0] row;
        logic [CW-1:0] wdata;

        always_comb begin
            sel_a   = exec_a & (cur_a.addr[0] == 1'(b));
            sel_b   = exec_b & (cur_b.addr[0] == 1'(b));
            row     = sel_a ? cur_a.addr[ADDR_WIDTH-1:1] : cur_b.addr[ADDR_WIDTH-1:1];
            bank_we = sel_a ? cur_a.we : (sel_b & cur_b.we);
            wdata   = sel_a ? (ecc_encode(cur_a.din) ^ cur_a.mask)
                            : (ecc_encode(cur_b.din) ^ cur_b.mask);
        end

        always_ff @(posedge clk) begin
            if (bank_we) mem[row] <= wdata;
            rdata_q <= mem[row];
        end

        assign bank_rd[b] = rdata_q;
    end

    always_comb begin
        dec_a = ecc_decode(bank_rd[rd_bank_a_q]);
        dec_b = ecc_decode(bank_rd[rd_bank_b_q]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_a_v_q  <= 1'b0;
            hold_b_v_q  <= 1'b0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            ptr_q       <= 1'b0;
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
            rd_bank_a_q <= 1'b0;
            rd_bank_b_q <= 1'b0;
            o_douta     <= '0;
            o_doutb     <= '0;
            o_vala      <= 1'b0;
            o_valb      <= 1'b0;
            o_sbea      <= 1'b0;
            o_sbeb      <= 1'b0;
            o_dbea      <= 1'b0;
            o_dbeb      <= 1'b0;
        end else begin
            hold_a_v_q <= lose_a;
            hold_b_v_q <= lose_b;
            if (lose_a) hold_a_q <= cur_a;
            if (lose_b) hold_b_q <= cur_b;
            ptr_q       <= ptr_q ^ fresh_pair;
            rd_pend_a_q <= exec_a & ~cur_a.we;
            rd_pend_b_q <= exec_b & ~cur_b.we;
            rd_bank_a_q <= cur_a.addr[0];
            rd_bank_b_q <= cur_b.addr[0];
            o_vala      <= rd_pend_a_q;
            o_valb      <= rd_pend_b_q;
            o_sbea      <= rd_pend_a_q & dec_a.sbe;
            o_sbeb      <= rd_pend_b_q & dec_b.sbe;
            o_dbea      <= rd_pend_a_q & dec_a.dbe;
            o_dbeb      <= rd_pend_b_q & dec_b.dbe;
            if (rd_pend_a_q) o_douta <= dec_a.data;
            if (rd_pend_b_q) o_doutb <= dec_b.data;
        end
    end

endmodule

// File: tb/tb_ecc_bank_resp.sv
// Bench for ecc_bank_resp: directed vector table, hand sequences for reset-time collision
// and (with ECC_ERR_INJ_EN) error injection, then randomized traffic against a reference model.
module tb_ecc_bank_resp;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena, enb, wea, web;
    logic [DW-1:0] dina, dinb;
    logic [AW-1:0] addra, addrb;
    logic          rdya, rdyb, vala, valb, sbea, sbeb, dbea, dbeb;
    logic [DW-1:0] douta, doutb;
`ifdef ECC_ERR_INJ_EN
    logic [CW-1:0] inj_ma, inj_mb;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    ecc_bank_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
        .i_dina(dina), .i_dinb(dinb), .i_addra(addra), .i_addrb(addrb),
`ifdef ECC_ERR_INJ_EN
        .i_inj_maska(inj_ma), .i_inj_maskb(inj_mb),
`endif
        .o_rdya(rdya), .o_rdyb(rdyb), .o_douta(douta), .o_doutb(doutb),
        .o_vala(vala), .o_valb(valb), .o_sbea(sbea), .o_sbeb(sbeb),
        .o_dbea(dbea), .o_dbeb(dbeb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        ena = 0; wea = 0; dina = '0; addra = '0;
        enb = 0; web = 0; dinb = '0; addrb = '0;
`ifdef ECC_ERR_INJ_EN
        inj_ma = '0; inj_mb = '0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          ena, wea;
        logic [AW-1:0] addra;
        logic [DW-1:0] dina;
        logic          enb, web;
        logic [AW-1:0] addrb;
        logic [DW-1:0] dinb;
        logic          rdya, rdyb, vala;
        logic [DW-1:0] douta;
        logic          valb;
        logic [DW-1:0] doutb;
    } vec_t;

    function automatic vec_t mk(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                                input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                                input logic ra, input logic rb, input logic va, input logic [DW-1:0] qa,
                                input logic vb, input logic [DW-1:0] qb);
        vec_t v;
        v.ena = ea; v.wea = wa; v.addra = aa; v.dina = da;
        v.enb = eb; v.web = wb; v.addrb = ab; v.dinb = db;
        v.rdya = ra; v.rdyb = rb; v.vala = va; v.douta = qa; v.valb = vb; v.doutb = qb;
        return v;
    endfunction

    vec_t tbl[14];

    // ---------------- reference model ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } mreq_t;

    logic [DW-1:0] ref_mem [64];
    logic          m_held_a, m_held_b, m_ptr;
    mreq_t         m_hreq_a, m_hreq_b;
    logic [DW-1:0] exp_qa[$], exp_qb[$];
    int            exp_ta[$], exp_tb[$];

    task automatic model_reset();
        m_held_a = 0; m_held_b = 0; m_ptr = 0;
        exp_qa.delete(); exp_qb.delete(); exp_ta.delete(); exp_tb.delete();
    endtask

    // One rising edge: decide who runs, who waits, then apply the winners to the memory image.
    task automatic model_edge(input logic ea, input mreq_t fa, input logic eb, input mreq_t fb);
        logic  va, vb, la, lb;
        mreq_t ca, cb;
        va = m_held_a || ea;
        vb = m_held_b || eb;
        ca = m_held_a ? m_hreq_a : fa;
        cb = m_held_b ? m_hreq_b : fb;
        la = 0; lb = 0;
        if (va && vb && (ca.addr[0] == cb.addr[0])) begin
            if (m_held_a) lb = 1;
            else if (m_held_b) la = 1;
            else begin
                if (m_ptr) la = 1; else lb = 1;
                m_ptr = !m_ptr;
            end
        end
        m_held_a = la;
        m_held_b = lb;
        if (la) m_hreq_a = ca;
        if (lb) m_hreq_b = cb;
        if (va && !la) begin
            if (ca.we) ref_mem[ca.addr] = ca.din;
            else begin exp_qa.push_back(ref_mem[ca.addr]); exp_ta.push_back(cyc + 1); end
        end
        if (vb && !lb) begin
            if (cb.we) ref_mem[cb.addr] = cb.din;
            else begin exp_qb.push_back(ref_mem[cb.addr]); exp_tb.push_back(cyc + 1); end
        end
    endtask

    task automatic check_outputs();
        check("rdya", rdya, !m_held_a);
        check("rdyb", rdyb, !m_held_b);
        if (exp_ta.size() > 0 && exp_ta[0] == cyc) begin
            void'(exp_ta.pop_front());
            check("a_val", vala, 1);
            check("a_dout", douta, exp_qa.pop_front());
            check("a_flags", {sbea, dbea}, 2'b00);
        end else check("a_val_idle", vala, 0);
        if (exp_tb.size() > 0 && exp_tb[0] == cyc) begin
            void'(exp_tb.pop_front());
            check("b_val", valb, 1);
            check("b_dout", doutb, exp_qb.pop_front());
            check("b_flags", {sbeb, dbeb}, 2'b00);
        end else check("b_val_idle", valb, 0);
    endtask

    task automatic run_cycle();
        mreq_t fa, fb;
        logic  ea, eb;
        fa.we = wea; fa.addr = addra; fa.din = dina;
        fb.we = web; fb.addr = addrb; fb.din = dinb;
        ea = ena && !m_held_a;
        eb = enb && !m_held_b;
        tick();
        model_edge(ea, fa, eb, fb);
        check_outputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values ----
        do_reset();
        check("rst_rdya", rdya, 1);
        check("rst_rdyb", rdyb, 1);
        check("rst_douta", douta, 0);
        check("rst_doutb", doutb, 0);
        check("rst_vals", {vala, valb}, 0);
        check("rst_flags", {sbea, sbeb, dbea, dbeb}, 0);

        // ---- directed table ----
        tbl[0]  = mk(1,1,6'h04,8'hA5, 0,0,6'h00,8'h00, 1,1, 0,8'h00, 0,8'h00);
        tbl[1]  = mk(1,0,6'h04,8'h00, 0,0,6'h00,8'h00, 1,1, 0,8'h00, 0,8'h00);
        tbl[2]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 1,1, 1,8'hA5, 0,8'h00);
        tbl[3]  = mk(1,1,6'h02,8'h11, 1,1,6'h03,8'h22, 1,1, 0,8'hA5, 0,8'h00);
        tbl[4]  = mk(1,1,6'h06,8'h33, 0,0,6'h00,8'h00, 1,1, 0,8'hA5, 0,8'h00);
        tbl[5]  = mk(1,0,6'h02,8'h00, 1,0,6'h03,8'h00, 1,1, 0,8'hA5, 0,8'h00);
        tbl[6]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 1,1, 1,8'h11, 1,8'h22);
        tbl[7]  = mk(1,0,6'h02,8'h00, 1,0,6'h06,8'h00, 1,0, 0,8'h11, 0,8'h22);
        tbl[8]  = mk(1,0,6'h04,8'h00, 1,0,6'h06,8'h00, 0,1, 1,8'h11, 0,8'h22);
        tbl[9]  = mk(1,0,6'h04,8'h00, 0,0,6'h00,8'h00, 1,1, 0,8'h11, 1,8'h33);
        tbl[10] = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 1,1, 1,8'hA5, 0,8'h33);
        tbl[11] = mk(1,0,6'h02,8'h00, 1,0,6'h06,8'h00, 0,1, 0,8'hA5, 0,8'h33);
        tbl[12] = mk(1,0,6'h02,8'h00, 0,0,6'h00,8'h00, 1,1, 0,8'hA5, 1,8'h33);
        tbl[13] = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 1,1, 1,8'h11, 0,8'h33);
        for (int i = 0; i < 14; i++) begin
            ena = tbl[i].ena; wea = tbl[i].wea; addra = tbl[i].addra; dina = tbl[i].dina;
            enb = tbl[i].enb; web = tbl[i].web; addrb = tbl[i].addrb; dinb = tbl[i].dinb;
            tick();
            check($sformatf("tbl%0d_rdya", i), rdya, tbl[i].rdya);
            check($sformatf("tbl%0d_rdyb", i), rdyb, tbl[i].rdyb);
            check($sformatf("tbl%0d_vala", i), vala, tbl[i].vala);
            check($sformatf("tbl%0d_valb", i), valb, tbl[i].valb);
            check($sformatf("tbl%0d_douta", i), douta, tbl[i].douta);
            check($sformatf("tbl%0d_doutb", i), doutb, tbl[i].doutb);
            if (tbl[i].vala) check($sformatf("tbl%0d_flagsa", i), {sbea, dbea}, 2'b00);
            if (tbl[i].valb) check($sformatf("tbl%0d_flagsb", i), {sbeb, dbeb}, 2'b00);
        end

        // ---- same-address write/read collision right after reset: A wins ----
        do_reset();
        ena = 1; wea = 1; addra = 6'h08; dina = 8'h5A;
        enb = 1; web = 0; addrb = 6'h08;
        tick();
        check("wr_rd_rdya", rdya, 1);
        check("wr_rd_rdyb", rdyb, 0);
        ena = 0;
        tick();
        check("wr_rd_rdyb_back", rdyb, 1);
        check("wr_rd_valb_early", valb, 0);
        idle_inputs();
        tick();
        check("wr_rd_valb", valb, 1);
        check("wr_rd_doutb", doutb, 8'h5A);
        check("wr_rd_flagsb", {sbeb, dbeb}, 2'b00);

`ifdef ECC_ERR_INJ_EN
        // ---- error injection: single flip corrected, double flip detected ----
        for (int t = 0; t < 2; t++) begin
            do_reset();
            ena = 1; wea = 1; addra = 6'h01; dina = 8'hA5;
            inj_ma = (t == 0) ? 13'h0008 : 13'h0006;
            tick();
            wea = 0; inj_ma = '0;
            tick();
            idle_inputs();
            tick();
            check($sformatf("inj%0d_val", t), vala, 1);
            check($sformatf("inj%0d_sbe", t), sbea, (t == 0) ? 1 : 0);
            check($sformatf("inj%0d_dbe", t), dbea, (t == 0) ? 0 : 1);
            if (t == 0) check("inj0_dout", douta, 8'hA5);
        end
`endif

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int r = 0; r < 32; r++) begin
            ena = 1; wea = 1; addra = 6'(2 * r);     dina = 8'($urandom);
            enb = 1; web = 1; addrb = 6'(2 * r + 1); dinb = 8'($urandom);
            run_cycle();
        end
        for (int n = 0; n < 1500; n++) begin
            if (!m_held_a) begin
                ena = ($urandom_range(0, 3) != 0); wea = ($urandom_range(0, 2) == 0);
                addra = 6'($urandom_range(0, 63)); dina = 8'($urandom);
            end
            if (!m_held_b) begin
                enb = ($urandom_range(0, 3) != 0); web = ($urandom_range(0, 2) == 0);
                addrb = 6'($urandom_range(0, 63)); dinb = 8'($urandom);
            end
            run_cycle();
        end
        idle_inputs();
        for (int d = 0; d < 6; d++) run_cycle();
        check("drain_a", exp_ta.size(), 0);
        check("drain_b", exp_tb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
